// File: rtl/dma_io_rx_channel_if.sv
// Bundles the config, device handshake, memory write and status signals of the RX DMA channel.
// Latency: wires only, no state.
// Backpressure: none; the device paces the transfer through gpio_req.
interface dma_io_rx_channel_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13,
    parameter int CNT_W  = 6
);
    // CPU configuration port
    logic              cfg_we;
    logic [1:0]        cfg_sel;
    logic [DATA_W-1:0] cfg_wdata;

    // I/O device handshake
    logic              gpio_req;
    logic              dev_ack;
    logic              dev_iowrite;
    logic [DATA_W-1:0] dev_data;

    // Memory write port
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // Status toward the CPU
    logic              busy;
    logic              done_irq;
    logic              short_xfer;
    logic [CNT_W-1:0]  words_done;

    // DMA engine side
    modport master (
        input  cfg_we, cfg_sel, cfg_wdata, gpio_req, dev_data,
        output dev_ack, dev_iowrite, mem_we, mem_addr, mem_wdata,
        output busy, done_irq, short_xfer, words_done
    );

    // CPU / device / memory side
    modport slave (
        output cfg_we, cfg_sel, cfg_wdata, gpio_req, dev_data,
        input  dev_ack, dev_iowrite, mem_we, mem_addr, mem_wdata,
        input  busy, done_irq, short_xfer, words_done
    );
endinterface

// File: rtl/dma_io_rx_channel.sv
// Single-channel receive DMA: drains the GPIO device word buffer into consecutive memory words.
// Latency: first mem_we two cycles after the SYNC cycle, then one word per cycle with no gaps.
// Backpressure: memory always accepts; a dropped gpio_req ends the burst early (short_xfer).
module dma_io_rx_channel #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dma_io_rx_channel_if.master   bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_SYNC  = 3'd2,
        ST_XFER  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Programmed transfer descriptor
    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [CNT_W-1:0]  count;
    } cfg_t;

    localparam logic [1:0] SEL_BASE  = 2'd0;
    localparam logic [1:0] SEL_COUNT = 2'd1;
    localparam logic [1:0] SEL_CTRL  = 2'd2;

    state_t            state_q;
    state_t            state_d;
    cfg_t              cfg_q;

    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              done_irq_q;
    logic              short_xfer_q;
    logic [CNT_W-1:0]  words_done_q;

    logic              in_idle;
    logic              base_wr;
    logic              count_wr;
    logic              ctrl_wr;
    logic              start_acc;
    logic              irq_clr;
    logic [CNT_W-1:0]  words_next;
    logic              last_word;
    logic              capture;
    logic              early_stop;
    logic              dev_ack_c;
    logic              busy_c;
    logic              cfg_unused;

    // Upper config data bits carry no meaning for this block.
    assign cfg_unused = ^bus.cfg_wdata[DATA_W-1:ADDR_W];

    // Config decode: descriptor writes only land in IDLE, irq clear lands anytime.
    assign in_idle   = (state_q == ST_IDLE);
    assign base_wr   = bus.cfg_we && (bus.cfg_sel == SEL_BASE)  && in_idle;
    assign count_wr  = bus.cfg_we && (bus.cfg_sel == SEL_COUNT) && in_idle;
    assign ctrl_wr   = bus.cfg_we && (bus.cfg_sel == SEL_CTRL);
    assign irq_clr   = ctrl_wr && bus.cfg_wdata[1];
    assign start_acc = ctrl_wr && bus.cfg_wdata[0] && in_idle && (cfg_q.count != '0);

    // Transfer decode. The final word is taken even if the request drops on that same
    // edge, so a simultaneous drop still counts as a complete transfer.
    assign words_next = words_done_q + 1'b1;
    assign last_word  = (words_next == cfg_q.count);
    assign capture    = (state_q == ST_XFER) && (bus.gpio_req || last_word);
    assign early_stop = (state_q == ST_XFER) && !bus.gpio_req && !last_word;

    // State register; async reset returns the handshake to idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_d   = state_q;
        dev_ack_c = 1'b0;
        busy_c    = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (start_acc) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (bus.gpio_req) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                // Device needs one acknowledged cycle before its first word is valid.
                dev_ack_c = 1'b1;
                state_d   = ST_XFER;
            end
            ST_XFER: begin
                dev_ack_c = 1'b1;
                if (early_stop || (capture && last_word)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Descriptor registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= '0;
        end else begin
            if (base_wr) begin
                cfg_q.base <= bus.cfg_wdata[ADDR_W-1:0];
            end
            if (count_wr) begin
                cfg_q.count <= bus.cfg_wdata[CNT_W-1:0];
            end
        end
    end

    // Memory write pipeline: each captured word is written on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= capture;
            if (capture) begin
                mem_wdata_q <= bus.dev_data;
                // Address wraps naturally at the top of memory.
                mem_addr_q  <= cfg_q.base + ADDR_W'(words_done_q);
            end
        end
    end

    // Word counter and early-termination flag, both restarted by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_done_q <= '0;
            short_xfer_q <= 1'b0;
        end else begin
            if (start_acc) begin
                words_done_q <= '0;
                short_xfer_q <= 1'b0;
            end else begin
                if (capture) begin
                    words_done_q <= words_next;
                end
                if (early_stop) begin
                    short_xfer_q <= 1'b1;
                end
            end
        end
    end

    // Sticky completion interrupt; only an explicit clear removes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_irq_q <= 1'b0;
        end else begin
            if (state_q == ST_DONE) begin
                done_irq_q <= 1'b1;
            end else if (irq_clr) begin
                done_irq_q <= 1'b0;
            end
        end
    end

    assign bus.dev_ack     = dev_ack_c;
    assign bus.dev_iowrite = !dev_ack_c;
    assign bus.busy        = busy_c;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.done_irq    = done_irq_q;
    assign bus.short_xfer  = short_xfer_q;
    assign bus.words_done  = words_done_q;

endmodule

// File: tb/tb_dma_io_rx_channel.sv
// Randomized scoreboard bench for dma_io_rx_channel with a behavioural device model.
// Latency: expected writes land two cycles after the first acknowledged cycle, then back to back.
// Backpressure: the device model drops gpio_req after a chosen number of captured words.
module tb_dma_io_rx_channel;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 13;
    localparam int CNT_W  = 6;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dma_io_rx_channel_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    dma_io_rx_channel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [DATA_W-1:0] words[64];
    int drop_after = 1000;
    int ackneg = 0;
    int p_idx;
    int cyc = 0;
    int sync_cyc = 0;
    logic gpio_en = 1'b0;
    logic gpio_drop = 1'b0;
    logic irq_model = 1'b0;

    assign bus.gpio_req = gpio_en && !gpio_drop;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Device model: word 0 is on the bus for the first two acknowledged cycles, then one
    // new word per cycle; the request is withdrawn after drop_after captured words.
    always @(negedge clk) begin
        if (bus.dev_ack) begin
            ackneg = ackneg + 1;
            if (ackneg == 1) sync_cyc = cyc;
            p_idx = (ackneg >= 2) ? ackneg - 2 : 0;
            bus.dev_data = words[p_idx % 64];
            gpio_drop = (ackneg >= drop_after + 2);
        end else begin
            ackneg = 0;
            gpio_drop = 1'b0;
            bus.dev_data = $urandom;
        end
    end

    // Monitor: every memory write must match the oldest expected write and its cycle slot.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("iowrite_vs_ack", bus.dev_iowrite, !bus.dev_ack);
            if (bus.mem_we) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", bus.mem_addr, bus.mem_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("mem_addr", bus.mem_addr, mon_e.addr);
                    chk("mem_wdata", bus.mem_wdata, mon_e.data);
                    chk("write_cycle", cyc - sync_cyc, 2 + mon_e.idx);
                end
            end
        end
    end

    task automatic cfg_write(input logic [1:0] sel, input logic [31:0] d);
        @(negedge clk);
        bus.cfg_we = 1'b1;
        bus.cfg_sel = sel;
        bus.cfg_wdata = d;
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (bus.busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (bus.busy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, t);
        end
    endtask

    // One transfer: base, count, request withdrawn after `drop` words, control value,
    // cycles to hold the request low while armed, and whether to poke config while busy.
    task automatic run_xfer(input logic [ADDR_W-1:0] base, input int cnt, input int drop,
                            input logic [31:0] ctrl, input int delay, input bit poke);
        int nw;
        logic exp_irq;
        for (int i = 0; i < 64; i++) words[i] = $urandom;
        nw = (drop >= cnt - 1) ? cnt : drop;
        drop_after = drop;
        cfg_write(2'd0, 32'(base));
        cfg_write(2'd1, 32'(cnt));
        for (int i = 0; i < nw; i++) begin
            exp_q.push_back('{addr: base + ADDR_W'(i), data: words[i], idx: i});
        end
        exp_irq = ctrl[1] ? 1'b0 : irq_model;
        cfg_write(2'd2, ctrl);
        chk("busy_after_start", bus.busy, 1);
        chk("irq_after_start", bus.done_irq, exp_irq);
        if (poke) begin
            cfg_write(2'd0, 32'(~base));
            cfg_write(2'd1, 32'((cnt + 7) % 64));
        end
        repeat (delay) @(negedge clk);
        if (delay > 0 || poke) begin
            chk("ack_low_armed", bus.dev_ack, 0);
            chk("we_low_armed", bus.mem_we, 0);
            chk("busy_armed", bus.busy, 1);
        end
        gpio_en = 1'b1;
        wait_idle("xfer");
        gpio_en = 1'b0;
        irq_model = 1'b1;
        chk("words_done", bus.words_done, nw);
        chk("short_xfer", bus.short_xfer, (nw != cnt));
        chk("done_irq", bus.done_irq, 1);
        chk("pending_writes", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int t;
        int cnt;
        bus.cfg_we = 1'b0;
        bus.cfg_sel = 2'd0;
        bus.cfg_wdata = '0;
        for (int i = 0; i < 64; i++) words[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_dev_ack", bus.dev_ack, 0);
        chk("rst_iowrite", bus.dev_iowrite, 1);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_done_irq", bus.done_irq, 0);
        chk("rst_short", bus.short_xfer, 0);
        chk("rst_words_done", bus.words_done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_xfer(13'h100, 4, 1000, 32'h1, 0, 1'b0);
        run_xfer(13'h020, 8, 3, 32'h1, 2, 1'b0);
        run_xfer(13'h1FFE, 4, 1000, 32'h1, 1, 1'b0);
        run_xfer(13'h0A0, 5, 4, 32'h1, 0, 1'b0);

        // Start with zero count is ignored even with the request raised
        gpio_en = 1'b1;
        cfg_write(2'd1, 32'd0);
        cfg_write(2'd2, 32'h1);
        for (int i = 0; i < 3; i++) begin
            chk("zero_cnt_busy", bus.busy, 0);
            chk("zero_cnt_ack", bus.dev_ack, 0);
            @(negedge clk);
        end
        gpio_en = 1'b0;

        run_xfer(13'h040, 5, 1000, 32'h1, 6, 1'b0);
        run_xfer(13'h200, 6, 1000, 32'h3, 3, 1'b1);

        // Reset during the transfer
        for (int i = 0; i < 64; i++) words[i] = $urandom;
        drop_after = 1000;
        cfg_write(2'd0, 32'h30);
        cfg_write(2'd1, 32'd8);
        for (int i = 0; i < 8; i++) exp_q.push_back('{addr: 13'h30 + ADDR_W'(i), data: words[i], idx: i});
        cfg_write(2'd2, 32'h1);
        gpio_en = 1'b1;
        t = 0;
        while (bus.words_done != 6'd2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (bus.words_done != 6'd2) begin
            n_cmp++;
            n_fail++;
            $display("FAIL midreset_timeout: words_done 0x%0h, required 0x2", bus.words_done);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ack", bus.dev_ack, 0);
        chk("midrst_iowrite", bus.dev_iowrite, 1);
        chk("midrst_mem_we", bus.mem_we, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_words", bus.words_done, 0);
        chk("midrst_irq", bus.done_irq, 0);
        exp_q.delete();
        gpio_en = 1'b0;
        irq_model = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized transfers
        for (int n = 0; n < 25; n++) begin
            cnt = $urandom_range(1, 32);
            run_xfer(ADDR_W'($urandom), cnt,
                     ($urandom_range(0, 1) == 0) ? 1000 : $urandom_range(0, cnt + 1),
                     32'h1 | (32'($urandom_range(0, 1)) << 1),
                     $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
